ssd_debug_display: RTL and testbench

//   Debug read-out end of the processor's register/PC observation path. Samples
//   the register-file debug read port (selected by reg_index) or the PC (pc_read=1),

---
 rtl/ssd_debug_display_if.sv | 21 ++
 rtl/ssd_debug_display.sv | 133 +++++++++++++
 tb/tb_ssd_debug_display.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ssd_debug_display_if.sv
// Debug observation bus between the datapath/register file and the seven-segment read-out.
// The master side owns selection and read data; the slave (display) owns the read address and pins.
interface ssd_debug_display_if;
    logic [4:0]  reg_index;
    logic        pc_read;
    logic [31:0] pc_value;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [6:0]  ssd;
    logic [3:0]  a;

    modport master (
        output reg_index, pc_read, pc_value, rf_rdata,
        input  rf_raddr, ssd, a
    );

    modport slave (
        input  reg_index, pc_read, pc_value, rf_rdata,
        output rf_raddr, ssd, a
    );
endinterface

// File: rtl/ssd_debug_display.sv
// Samples a register (or the PC) into a 32-bit snapshot and scans it as hex
// onto a 4-digit active-low seven-segment display, 16 bits per page.
module ssd_debug_display #(
    parameter int SCAN_BITS   = 18,
    parameter int PAGE_BITS   = 27,
    parameter int SAMPLE_BITS = 20
) (
    input  logic                clk,
    input  logic                reset,
    ssd_debug_display_if.slave  dbg
);
    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_e;

    logic [1:0]             rst_sync_q, rst_sync_d;
    logic                   rst_n;
    logic [SCAN_BITS-1:0]   scan_cnt_q, scan_cnt_d;
    logic [PAGE_BITS-1:0]   page_cnt_q, page_cnt_d;
    logic [SAMPLE_BITS-1:0] samp_cnt_q, samp_cnt_d;
    logic [1:0]             digit_q, digit_d;
    logic                   page_q, page_d;
    state_e                 state_q, state_d;
    logic [5:0]             sel_q, sel_d;
    logic [4:0]             raddr_q, raddr_d;
    logic [31:0]            snap_q, snap_d;
    logic [6:0]             ssd_q, ssd_d;
    logic [3:0]             a_q, a_d;
    logic [5:0]             sel_in;
    logic [15:0]            shown;
    logic [3:0]             nibble;

    // Assertion is immediate; release reaches the core two clocks later.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end
    assign rst_n = rst_sync_q[1];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign sel_in = {dbg.pc_read, dbg.reg_index};

    // Sample FSM: selection and read address are latched on entry to REQ so
    // rf_rdata lines up with the CAPT cycle.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        raddr_d    = raddr_q;
        snap_d     = snap_q;
        samp_cnt_d = samp_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                if ((&samp_cnt_q) || (sel_in != sel_q)) begin
                    state_d = REQ;
                    sel_d   = sel_in;
                    raddr_d = dbg.reg_index;
                end
            end
            REQ: state_d = CAPT;
            CAPT: begin
                snap_d     = sel_q[5] ? dbg.pc_value : dbg.rf_rdata;
                samp_cnt_d = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan/page: segments and anode come from the same digit so they always pair up.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        page_cnt_d = page_cnt_q + 1'b1;
        digit_d    = (&scan_cnt_q) ? digit_q + 1'b1 : digit_q;
        page_d     = (&page_cnt_q) ? ~page_q : page_q;
        shown      = page_q ? snap_q[31:16] : snap_q[15:0];
        nibble     = shown[{digit_q, 2'b00} +: 4];
        ssd_d      = hex7(nibble);
        a_d        = ~(4'b0001 << digit_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            page_cnt_q <= '0;
            samp_cnt_q <= '0;
            digit_q    <= 2'd0;
            page_q     <= 1'b0;
            state_q    <= IDLE;
            sel_q      <= '0;
            raddr_q    <= '0;
            snap_q     <= '0;
            ssd_q      <= 7'b1111111;
            a_q        <= 4'b1111;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            page_cnt_q <= page_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            digit_q    <= digit_d;
            page_q     <= page_d;
            state_q    <= state_d;
            sel_q      <= sel_d;
            raddr_q    <= raddr_d;
            snap_q     <= snap_d;
            ssd_q      <= ssd_d;
            a_q        <= a_d;
        end
    end

    assign dbg.rf_raddr = raddr_q;
    assign dbg.ssd      = ssd_q;
    assign dbg.a        = a_q;
endmodule

// File: tb/tb_ssd_debug_display.sv
// Scoreboard bench: each stimulus pushes the snapshot it should produce; the scan
// checker pops it and compares every displayed digit against a timing model.
module tb_ssd_debug_display;
    localparam int SCAN_BITS   = 2;
    localparam int PAGE_BITS   = 6;
    localparam int SAMPLE_BITS = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   run_cyc = 0;
    logic [31:0] regs [32];
    logic [31:0] exp_q [$];
    logic [6:0]  seg_lut [16];

    ssd_debug_display_if bus ();

    ssd_debug_display #(
        .SCAN_BITS  (SCAN_BITS),
        .PAGE_BITS  (PAGE_BITS),
        .SAMPLE_BITS(SAMPLE_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .dbg  (bus.slave)
    );

    always #5 clk = ~clk;

    // Register file debug port: data valid one cycle after the address.
    always @(posedge clk) bus.rf_rdata <= regs[bus.rf_raddr];

    // Cycles since reset release; the core starts counting two edges in.
    always @(posedge clk or negedge reset) begin
        if (!reset) run_cyc <= 0;
        else        run_cyc <= run_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic scan_chk(input string tag, input int ncyc);
        logic [31:0] snap;
        logic [15:0] half;
        logic [3:0]  a_exp;
        logic [3:0]  nib;
        int          n, dig;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        snap = exp_q.pop_front();
        repeat (ncyc) begin
            @(negedge clk);
            n     = run_cyc - 3;
            dig   = (n / (1 << SCAN_BITS)) % 4;
            half  = (((n / (1 << PAGE_BITS)) % 2) == 1) ? snap[31:16] : snap[15:0];
            nib   = half[4*dig +: 4];
            a_exp = ~(4'b0001 << dig);
            chk({tag, "_a"}, {28'd0, bus.a}, {28'd0, a_exp});
            chk({tag, "_ssd"}, {25'd0, bus.ssd}, {25'd0, seg_lut[nib]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit hit;
        seg_lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        for (int i = 0; i < 32; i++) regs[i] = 32'h5A00_0000 + 32'(i * 32'h0101);
        regs[0]  = 32'h0;
        regs[5]  = 32'hDEAD_BEEF;
        regs[28] = 32'h0123_4567;
        bus.reg_index = 5'd0;
        bus.pc_read   = 1'b0;
        bus.pc_value  = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_ssd", {25'd0, bus.ssd}, {25'd0, 7'b1111111});
        chk("rst_a", {28'd0, bus.a}, {28'd0, 4'b1111});
        chk("rst_raddr", {27'd0, bus.rf_raddr}, 32'd0);
        reset = 1'b1;

        // PC observation, both pages
        bus.pc_value = 32'h0000_001C;
        bus.pc_read  = 1'b1;
        exp_q.push_back(32'h0000_001C);
        repeat (8) @(negedge clk);
        scan_chk("pc", 140);

        // x0 reads as zero
        bus.pc_read   = 1'b0;
        bus.reg_index = 5'd0;
        exp_q.push_back(32'h0);
        repeat (8) @(negedge clk);
        scan_chk("x0", 40);

        // index change while a capture is in flight
        bus.reg_index = 5'd5;
        hit = 1'b0;
        for (int i = 0; i < 24 && !hit; i++) begin
            @(negedge clk);
            if (bus.rf_raddr == 5'd5) hit = 1'b1;
        end
        chk("req5", {31'd0, hit}, 32'd1);
        @(negedge clk);
        bus.reg_index = 5'd28;
        exp_q.push_back(regs[28]);
        @(negedge clk);
        chk("raddr_hold", {27'd0, bus.rf_raddr}, 32'd5);
        @(negedge clk);
        chk("req28", {27'd0, bus.rf_raddr}, 32'd28);
        repeat (6) @(negedge clk);
        scan_chk("x28", 40);

        // register read, both pages
        bus.reg_index = 5'd5;
        exp_q.push_back(32'hDEAD_BEEF);
        repeat (8) @(negedge clk);
        scan_chk("x5", 140);

        // constant selection: only the periodic resample picks up new data
        regs[5] = 32'hCAFE_0042;
        exp_q.push_back(32'hCAFE_0042);
        repeat ((1 << SAMPLE_BITS) + 8) @(negedge clk);
        scan_chk("resample", 40);

        // asynchronous reset mid-scan
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_ssd", {25'd0, bus.ssd}, {25'd0, 7'b1111111});
        chk("mid_rst_a", {28'd0, bus.a}, {28'd0, 4'b1111});
        chk("mid_rst_raddr", {27'd0, bus.rf_raddr}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_a", {28'd0, bus.a}, {28'd0, 4'b1111});
        bus.reg_index = 5'd28;
        reset = 1'b1;
        exp_q.push_back(regs[28]);
        repeat (10) @(negedge clk);
        scan_chk("post_rst", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
